uart_msg_tx: RTL and testbench

UART_MSG_TX -- requirements
Module: uart_msg_tx

---
 rtl/uart_msg_tx.sv | 107 ++++++++++
 tb/tb_uart_msg_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_tx.sv
// uart_msg_tx: serialises a packed message (optionally CR/LF terminated) onto a byte valid/ready stream
module uart_msg_tx #(
  parameter int MSG_LEN     = 32,
  parameter bit APPEND_CRLF = 1
) (
  input  logic                 clk_48mhz,
  input  logic                 reset,
  input  logic [8*MSG_LEN-1:0] msg_data,
  input  logic [5:0]           msg_len,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  output logic [7:0]           uart_in_data,
  output logic                 uart_in_valid,
  input  logic                 uart_in_ready,
  output logic                 busy,
  output logic                 done
);
  localparam int IW = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1;
  localparam logic [6:0] MAX_L = 7'(MSG_LEN);
  typedef enum logic [1:0] {IDLE, SEND, CR, LF} state_t;
  state_t state;
  logic [8*MSG_LEN-1:0] msg_q;
  logic [IW-1:0] idx, first_idx, next_idx;
  logic [6:0] eff_len;
  logic accept, hs;
  // clamp the offered length and derive the first/next byte positions
  always_comb begin
    eff_len   = ({1'b0, msg_len} > MAX_L) ? MAX_L : {1'b0, msg_len};
    first_idx = IW'(eff_len - 7'd1);
    next_idx  = idx - 1'b1;
    accept    = msg_valid && msg_ready;
    hs        = uart_in_valid && uart_in_ready;
  end
  // message sequencer; every output is registered so the byte stays stable until accepted
  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      msg_q         <= '0;
      idx           <= '0;
      uart_in_data  <= 8'h00;
      uart_in_valid <= 1'b0;
      msg_ready     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          msg_ready <= 1'b1;
          if (accept) begin
            msg_q <= msg_data;
            if (eff_len != 7'd0) begin
              state         <= SEND;
              idx           <= first_idx;
              uart_in_data  <= msg_data[8*first_idx +: 8];
              uart_in_valid <= 1'b1;
              msg_ready     <= 1'b0;
              busy          <= 1'b1;
            end else if (APPEND_CRLF) begin
              state         <= CR;
              uart_in_data  <= 8'h0D;
              uart_in_valid <= 1'b1;
              msg_ready     <= 1'b0;
              busy          <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (hs) begin
            if (idx != '0) begin
              idx          <= next_idx;
              uart_in_data <= msg_q[8*next_idx +: 8];
            end else if (APPEND_CRLF) begin
              state        <= CR;
              uart_in_data <= 8'h0D;
            end else begin
              state         <= IDLE;
              uart_in_data  <= 8'h00;
              uart_in_valid <= 1'b0;
              msg_ready     <= 1'b1;
              busy          <= 1'b0;
              done          <= 1'b1;
            end
          end
        end
        CR: begin
          if (hs) begin
            state        <= LF;
            uart_in_data <= 8'h0A;
          end
        end
        LF: begin
          if (hs) begin
            state         <= IDLE;
            uart_in_data  <= 8'h00;
            uart_in_valid <= 1'b0;
            msg_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_msg_tx.sv
// tb_uart_msg_tx: scoreboard bench for uart_msg_tx with directed messages
module tb_uart_msg_tx;
  logic clk_48mhz = 1'b0;
  logic reset = 1'b0;
  logic [255:0] msg_data = '0;
  logic [5:0] msg_len = '0;
  logic msg_valid = 1'b0, msg_valid0 = 1'b0, uart_in_ready = 1'b1;
  logic msg_ready, uart_in_valid, busy, done;
  logic [7:0] uart_in_data;
  logic msg_ready0, uart_in_valid0, busy0, done0;
  logic [7:0] uart_in_data0;
  int errors = 0, checks = 0, done_cnt = 0, done0_cnt = 0, base, n;
  byte unsigned exp_q[$];

  uart_msg_tx #(.MSG_LEN(32), .APPEND_CRLF(1)) dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .msg_data(msg_data), .msg_len(msg_len),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .uart_in_data(uart_in_data),
    .uart_in_valid(uart_in_valid), .uart_in_ready(uart_in_ready), .busy(busy), .done(done));

  uart_msg_tx #(.MSG_LEN(32), .APPEND_CRLF(0)) dut0 (
    .clk_48mhz(clk_48mhz), .reset(reset), .msg_data(msg_data), .msg_len(msg_len),
    .msg_valid(msg_valid0), .msg_ready(msg_ready0), .uart_in_data(uart_in_data0),
    .uart_in_valid(uart_in_valid0), .uart_in_ready(1'b1), .busy(busy0), .done(done0));

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every accepted byte must be the next one the scoreboard expects
  always @(negedge clk_48mhz) begin
    if (uart_in_valid && uart_in_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected byte: got %0h expected none", uart_in_data);
      end else chk("byte", 32'(uart_in_data), 32'(exp_q.pop_front()));
    end
    if (uart_in_valid0) begin
      checks++;
      errors++;
      $display("FAIL nocrlf byte: got %0h expected none", uart_in_data0);
    end
    if (done) done_cnt++;
    if (done0) done0_cnt++;
  end

  task automatic sync;
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic send(input logic [255:0] d, input logic [5:0] len);
    chk("ready before send", 32'(msg_ready), 32'd1);
    msg_data = d;
    msg_len = len;
    msg_valid = 1'b1;
    sync();
    msg_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int exp_done);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 300) begin
      @(negedge clk_48mhz);
      k++;
    end
    chk({name, " drain"}, 32'(k < 300), 32'd1);
    @(negedge clk_48mhz);
    chk({name, " done count"}, 32'(done_cnt - base), 32'(exp_done));
  endtask

  initial begin
    #12;
    chk("rst valid", 32'(uart_in_valid), 0);
    chk("rst data", 32'(uart_in_data), 0);
    chk("rst ready", 32'(msg_ready), 0);
    chk("rst busy/done", 32'({busy, done}), 0);
    sync();
    reset = 1'b1;
    @(negedge clk_48mhz);
    chk("ready before first edge", 32'(msg_ready), 0);
    @(negedge clk_48mhz);
    chk("ready after release", 32'(msg_ready), 1);
    chk("busy idle", 32'(busy), 0);

    // "Hi" with CRLF, sink always ready
    sync();
    base = done_cnt;
    exp_q = '{8'h48, 8'h69, 8'h0D, 8'h0A};
    send(256'h4869, 6'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_48mhz);
      chk("hi consecutive valid", 32'(uart_in_valid && busy), 1);
    end
    @(negedge clk_48mhz);
    chk("hi done+ready", 32'({done, msg_ready, busy}), 32'b110);
    @(negedge clk_48mhz);
    chk("hi done single", 32'(done), 0);
    drain("hi", 1);

    // "ABC" with a 5-cycle stall on 0x42
    sync();
    base = done_cnt;
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A};
    send(256'h414243, 6'd3);
    sync();
    uart_in_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_48mhz);
      chk("stall hold", 32'({uart_in_valid, uart_in_data}), 32'h142);
    end
    sync();
    uart_in_ready = 1'b1;
    drain("abc", 1);

    // empty message with CRLF, and without CRLF on the second instance
    sync();
    base = done_cnt;
    exp_q = '{8'h0D, 8'h0A};
    send(256'h0, 6'd0);
    drain("len0", 1);
    sync();
    msg_valid0 = 1'b1;
    sync();
    msg_valid0 = 1'b0;
    @(negedge clk_48mhz);
    chk("nocrlf done", 32'({done0, msg_ready0, busy0}), 32'b110);
    @(negedge clk_48mhz);
    chk("nocrlf done single", 32'(done0), 0);
    chk("nocrlf done count", 32'(done0_cnt), 1);

    // length 40 clamps to 32
    sync();
    base = done_cnt;
    exp_q = {};
    for (int i = 0; i < 32; i++) msg_data[8*i +: 8] = 8'(i + 16);
    for (int i = 31; i >= 0; i--) exp_q.push_back(8'(i + 16));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    send(msg_data, 6'd40);
    drain("clamp", 1);

    // reset mid-message while byte 3 of 10 is presented
    sync();
    base = done_cnt;
    msg_data = '0;
    for (int i = 0; i < 10; i++) msg_data[8*i +: 8] = 8'(8'hA0 + i);
    exp_q = {};
    for (int i = 9; i >= 4; i--) exp_q.push_back(8'(8'hA0 + i));
    send(msg_data, 6'd10);
    repeat (6) @(posedge clk_48mhz);
    #1 uart_in_ready = 1'b0;
    @(negedge clk_48mhz);
    chk("byte3 presented", 32'({uart_in_valid, uart_in_data}), 32'h1A3);
    @(posedge clk_48mhz);
    #2 reset = 1'b0;
    #1;
    chk("async rst valid", 32'(uart_in_valid), 0);
    chk("async rst data/busy", 32'({uart_in_data, busy, msg_ready}), 0);
    sync();
    reset = 1'b1;
    uart_in_ready = 1'b1;
    repeat (12) @(negedge clk_48mhz);
    chk("after rst ready", 32'({msg_ready, busy}), 32'b10);
    chk("after rst queue", 32'(exp_q.size()), 0);
    chk("after rst no done", 32'(done_cnt - base), 0);

    // ignored mid-message offer, then back-to-back accept on the done cycle
    sync();
    base = done_cnt;
    exp_q = '{8'h58, 8'h59, 8'h0D, 8'h0A, 8'h51, 8'h0D, 8'h0A};
    send(256'h5859, 6'd2);
    msg_data = 256'h5A;
    msg_len = 6'd1;
    msg_valid = 1'b1;
    sync();
    msg_valid = 1'b0;
    sync();
    msg_data = 256'h51;
    msg_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk_48mhz);
      n++;
    end while (!done && n < 50);
    chk("b2b done seen", 32'(done && msg_ready), 1);
    sync();
    msg_valid = 1'b0;
    @(negedge clk_48mhz);
    chk("b2b first byte", 32'({uart_in_valid, uart_in_data}), 32'h151);
    drain("b2b", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
